// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle shared by the control FSM, the memory and mem_access_ctrl.
// slave: the access controller's view; master: the FSM/memory side that drives it.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [DATA_W-1:0] rdata_out;
    logic              rdata_valid;
    logic              stall;
    logic              err;
    logic [15:0]       stall_cycles;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  MemRead, MemWrite, addr_in, wdata_in, mem_rdata, mem_ack,
        output rdata_out, rdata_valid, stall, err, stall_cycles,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, addr_in, wdata_in, mem_rdata, mem_ack,
        input  rdata_out, rdata_valid, stall, err, stall_cycles,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Turns single-cycle MemRead/MemWrite strobes into a bounded req/ack memory access,
// stalling the control FSM until completion and counting stalled cycles.
module mem_access_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ABORT} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rdata_valid;
    logic              r_err;
    logic [15:0]       r_stall_cycles;

    logic              w_single;
    logic              w_illegal;
    logic              w_stall;

    assign w_single  = bus.MemRead ^ bus.MemWrite;
    assign w_illegal = bus.MemRead & bus.MemWrite;

    // The IDLE stall must hold the FSM in the same cycle the strobe appears.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_stall unassigned (no latch).
        w_stall = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE:    w_stall = w_single;
                ACCESS:  w_stall = 1'b1;
                default: w_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_wait_cnt     <= '0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_rdata_valid  <= 1'b0;
            r_err          <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            r_rdata_valid <= 1'b0;

            if (w_stall && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;

            case (r_state)
                IDLE: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_single) begin
                        r_we       <= bus.MemWrite;
                        r_addr     <= bus.addr_in;
                        r_wdata    <= bus.wdata_in;
                        r_wait_cnt <= '0;
                        r_req      <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end

                // Ack is tested before the timeout so an ack in the last allowed cycle wins.
                ACCESS: begin
                    if (bus.mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= DONE;
                        if (!r_we) begin
                            r_rdata       <= bus.mem_rdata;
                            r_rdata_valid <= 1'b1;
                        end
                    end else if (r_wait_cnt == TIMEOUT_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ABORT;
                        if (!r_we) begin
                            r_rdata       <= '0;
                            r_rdata_valid <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                DONE:    r_state <= IDLE;
                ABORT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mem_req      = r_req;
    assign bus.mem_we       = r_we;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign bus.rdata_out    = r_rdata;
    assign bus.rdata_valid  = r_rdata_valid;
    assign bus.err          = r_err;
    assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written reset and
// saturation sequences, and random transactions against a transaction-level model.
module tb_mem_access_ctrl;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 15;
  localparam int MAX_WAIT = 40;
  localparam int N_RAND   = 60;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BOTH} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;       // value the memory returns in its ack cycle
    int         ack_k;       // cycle of mem_ack, counted from the strobe (0 = never)
    int         exp_cycles;  // stalled cycles == cycle in which stall first drops
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_stall = 0;
  logic [7:0] model_rdata = 8'h00;
  logic       model_err = 1'b0;
  string      cur_tag = "init";
  vec_t       dir [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h at %0t", cur_tag, name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input op_e op, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] rdata, input int ack_k, input int exp_cycles,
                              input logic exp_valid, input logic [7:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack_k = ack_k;
    v.exp_cycles = exp_cycles; v.exp_valid = exp_valid; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err;
    return v;
  endfunction

  // Transaction-level reference: outcome follows from op and ack delay alone.
  function automatic vec_t predict(input op_e op, input logic [7:0] addr, input logic [7:0] wdata,
                                   input logic [7:0] rdata, input int k);
    vec_t v;
    v = mk(op, addr, wdata, rdata, k, 0, 1'b0, 8'h00, 1'b0);
    if (op == OP_BOTH) begin
      v.exp_cycles = 0;
      model_err = 1'b1;
    end else if (k >= 1 && k <= TIMEOUT) begin
      v.exp_cycles = k + 1;
      if (op == OP_READ) begin
        model_rdata = rdata;
        v.exp_valid = 1'b1;
      end
    end else begin
      v.exp_cycles = TIMEOUT + 1;
      model_err = 1'b1;
      if (op == OP_READ) begin
        model_rdata = 8'h00;
        v.exp_valid = 1'b1;
      end
    end
    v.exp_rdata = model_rdata;
    v.exp_err = model_err;
    return v;
  endfunction

  task automatic drive_idle();
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.addr_in   = 8'($urandom);
    bus.wdata_in  = 8'($urandom);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'($urandom);
  endtask

  task automatic do_reset();
    cur_tag = "reset";
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    #1;
    check("rdata_out", bus.rdata_out, 0);
    check("rdata_valid", bus.rdata_valid, 0);
    check("stall", bus.stall, 0);
    check("err", bus.err, 0);
    check("stall_cycles", bus.stall_cycles, 0);
    check("mem_req", bus.mem_req, 0);
    check("mem_we", bus.mem_we, 0);
    check("mem_addr", bus.mem_addr, 0);
    check("mem_wdata", bus.mem_wdata, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_stall = 0;
    model_rdata = 8'h00;
    model_err = 1'b0;
  endtask

  // Acts as control FSM plus memory: strobe held while stalled, dropped after it falls.
  task automatic run_vec(input vec_t v);
    int n;
    int comp;
    @(posedge clock); #1;
    bus.MemRead   = (v.op != OP_WRITE);
    bus.MemWrite  = (v.op != OP_READ);
    bus.addr_in   = v.addr;
    bus.wdata_in  = v.wdata;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'($urandom);
    n = 0;
    comp = -1;
    while (comp < 0 && n <= MAX_WAIT) begin
      @(negedge clock);
      if (!bus.stall) begin
        comp = n;
      end else begin
        check("valid_while_stall", bus.rdata_valid, 0);
        if (n == 0) begin
          check("req_cycle0", bus.mem_req, 0);
        end else begin
          check("req_held", bus.mem_req, 1);
          check("mem_we", bus.mem_we, (v.op == OP_WRITE));
          check("mem_addr", bus.mem_addr, v.addr);
          if (v.op == OP_WRITE) check("mem_wdata", bus.mem_wdata, v.wdata);
        end
        n++;
        @(posedge clock); #1;
        bus.addr_in   = 8'($urandom);
        bus.wdata_in  = 8'($urandom);
        bus.mem_ack   = (n == v.ack_k);
        bus.mem_rdata = (n == v.ack_k) ? v.rdata : 8'($urandom);
      end
    end
    exp_stall = (exp_stall + v.exp_cycles > 65535) ? 65535 : exp_stall + v.exp_cycles;
    check("done_cycle", comp, v.exp_cycles);
    check("done_req", bus.mem_req, 0);
    check("done_valid", bus.rdata_valid, v.exp_valid);
    check("done_rdata", bus.rdata_out, v.exp_rdata);
    check("stall_cycles", bus.stall_cycles, exp_stall);
    if (v.op != OP_BOTH && (v.ack_k < 1 || v.ack_k > TIMEOUT)) check("abort_err", bus.err, 1);
    @(posedge clock); #1;
    n++;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.mem_ack   = (n == v.ack_k);
    bus.mem_rdata = 8'($urandom);
    @(negedge clock);
    check("post_stall", bus.stall, 0);
    check("post_req", bus.mem_req, 0);
    check("post_valid", bus.rdata_valid, 0);
    check("post_err", bus.err, v.exp_err);
    check("post_rdata", bus.rdata_out, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    op_e  op;
    int   r;
    int   k;

    //                op        addr   wdata  rdata  ack cyc valid  rdata  err
    dir[0] = mk(OP_READ,  8'h21, 8'h00, 8'h5A,  2,  3, 1'b1, 8'h5A, 1'b0);
    dir[1] = mk(OP_WRITE, 8'h10, 8'hC3, 8'h00,  1,  2, 1'b0, 8'h5A, 1'b0);
    dir[2] = mk(OP_READ,  8'h33, 8'h00, 8'h77, 15, 16, 1'b1, 8'h77, 1'b0);
    dir[3] = mk(OP_WRITE, 8'h44, 8'h99, 8'h00,  3,  4, 1'b0, 8'h77, 1'b0);
    dir[4] = mk(OP_READ,  8'h55, 8'h00, 8'hEE,  0, 16, 1'b1, 8'h00, 1'b1);
    dir[5] = mk(OP_READ,  8'h66, 8'h00, 8'hA5,  1,  2, 1'b1, 8'hA5, 1'b1);
    dir[6] = mk(OP_WRITE, 8'h77, 8'h12, 8'h00, 16, 16, 1'b0, 8'hA5, 1'b1);
    dir[7] = mk(OP_READ,  8'h88, 8'h00, 8'hBB, 17, 16, 1'b1, 8'h00, 1'b1);

    drive_idle();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      cur_tag = $sformatf("dir%0d", i);
      run_vec(dir[i]);
    end

    // Reset in the middle of an access abandons it immediately.
    cur_tag = "mid_reset";
    @(posedge clock); #1;
    bus.MemRead = 1'b1;
    bus.addr_in = 8'h5C;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("req_before", bus.mem_req, 1);
    #1 reset = 1'b1;
    #1;
    check("req_in_reset", bus.mem_req, 0);
    check("stall_in_reset", bus.stall, 0);
    check("err_in_reset", bus.err, 0);
    check("cnt_in_reset", bus.stall_cycles, 0);
    bus.MemRead = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_stall = 0;
    model_rdata = 8'h00;
    model_err = 1'b0;
    cur_tag = "after_reset_read";
    run_vec(mk(OP_READ, 8'h3D, 8'h00, 8'h3C, 2, 3, 1'b1, 8'h3C, 1'b0));
    cur_tag = "illegal";
    run_vec(mk(OP_BOTH, 8'h4E, 8'h11, 8'h00, 0, 0, 1'b0, 8'h3C, 1'b1));

    do_reset();
    for (int i = 0; i < N_RAND; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      r = int'($urandom_range(0, 9));
      op = (r < 1) ? OP_BOTH : (r < 5) ? OP_READ : OP_WRITE;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(1, 6));
      v = predict(op, 8'($urandom), 8'($urandom), 8'($urandom), k);
      run_vec(v);
    end

    // Held read strobe with no ack: 17-cycle loop (IDLE + 15 ACCESS + ABORT), 16 stalled.
    do_reset();
    cur_tag = "saturate";
    @(posedge clock); #1;
    bus.MemRead = 1'b1;
    bus.mem_ack = 1'b0;
    repeat (1700) @(posedge clock);
    @(negedge clock);
    check("cnt_1700", bus.stall_cycles, 1600);
    repeat (73000) @(posedge clock);
    @(negedge clock);
    check("cnt_sat", bus.stall_cycles, 16'hFFFF);
    bus.MemRead = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("cnt_sat_hold", bus.stall_cycles, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
